// File: rtl/pll_reset_sequencer.sv
// Supervises the DVI clock PLL: drives RESETB, synchronises and qualifies LOCK,
// and releases the downstream DVI reset only after lock has been stable.
module pll_reset_sequencer #(
  parameter int W_CTR         = 16,
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 16000,
  parameter int STABLE_CYCLES = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_resetb,
  output logic       out_rst_n,
  output logic [1:0] state,
  output logic [7:0] timeout_count,
  output logic [7:0] loss_count
);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILISE = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam logic [W_CTR-1:0] RESET_LAST   = W_CTR'(RESET_CYCLES - 1);
  localparam logic [W_CTR-1:0] TIMEOUT_LAST = W_CTR'(LOCK_TIMEOUT - 1);
  localparam logic [W_CTR-1:0] STABLE_LAST  = W_CTR'(STABLE_CYCLES - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e           state_q, state_d;
  logic [W_CTR-1:0] ctr_q, ctr_d;
  logic             sync1_q, sync2_q;
  logic             pll_resetb_q, pll_resetb_d;
  logic             out_rst_n_q, out_rst_n_d;
  logic [7:0]       timeout_q, timeout_d;
  logic [7:0]       loss_q, loss_d;
  logic             locked_s;

  assign locked_s = sync2_q;

  // Two-flop synchroniser for the asynchronous PLL lock output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // Sequencer state, shared counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= PLL_RESET;
      ctr_q        <= {W_CTR{1'b0}};
      pll_resetb_q <= 1'b0;
      out_rst_n_q  <= 1'b0;
      timeout_q    <= 8'd0;
      loss_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      pll_resetb_q <= pll_resetb_d;
      out_rst_n_q  <= out_rst_n_d;
      timeout_q    <= timeout_d;
      loss_q       <= loss_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they change
  // on the same edge as the state they belong to.
  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q + W_CTR'(1);
    timeout_d = timeout_q;
    loss_d    = loss_q;
    case (state_q)
      PLL_RESET: begin
        if (ctr_q == RESET_LAST) begin
          state_d = WAIT_LOCK;
        end else begin
          state_d = PLL_RESET;
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a simultaneous timeout.
        if (locked_s) begin
          state_d = STABILISE;
        end else if (ctr_q == TIMEOUT_LAST) begin
          state_d   = PLL_RESET;
          timeout_d = sat_inc(timeout_q);
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      STABILISE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (ctr_q == STABLE_LAST) begin
          state_d = RUN;
        end else begin
          state_d = STABILISE;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          loss_d  = sat_inc(loss_q);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = PLL_RESET;
      end
    endcase
    if ((state_d != state_q) || (state_q == RUN)) begin
      ctr_d = {W_CTR{1'b0}};
    end else begin
      ctr_d = ctr_d;
    end
    pll_resetb_d = (state_d != PLL_RESET);
    out_rst_n_d  = (state_d == RUN);
  end

  assign pll_resetb    = pll_resetb_q;
  assign out_rst_n     = out_rst_n_q;
  assign state         = state_q;
  assign timeout_count = timeout_q;
  assign loss_count    = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer, using shortened
// cycle-count parameters so timeout saturation fits a short run.
module tb_pll_reset_sequencer;

  localparam int R     = 4;
  localparam int T     = 30;
  localparam int S     = 12;
  localparam int G     = 5;
  localparam int BOUND = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_resetb;
  logic       out_rst_n;
  logic [1:0] state;
  logic [7:0] timeout_count;
  logic [7:0] loss_count;

  int checks = 0;
  int failures = 0;

  pll_reset_sequencer #(
    .W_CTR(16), .RESET_CYCLES(R), .LOCK_TIMEOUT(T), .STABLE_CYCLES(S)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .pll_resetb(pll_resetb), .out_rst_n(out_rst_n), .state(state),
    .timeout_count(timeout_count), .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  task automatic apply_reset(input logic lock);
    rst_n = 1'b0;
    pll_locked = lock;
    repeat (3) @(negedge clk);
  endtask

  // Counts negedges until state equals tgt (bounded); ORs out_rst_n meanwhile.
  task automatic cycles_to_state(input logic [1:0] tgt, output int n, output logic rst_seen);
    n = 0;
    rst_seen = out_rst_n;
    while (state !== tgt && n < BOUND) begin
      @(negedge clk);
      n++;
      rst_seen = rst_seen | out_rst_n;
    end
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (pll_resetb !== 1'b0) begin failures++; $display("FAIL reset_pll_resetb got=%b exp=0", pll_resetb); end
    checks++; if (out_rst_n !== 1'b0) begin failures++; $display("FAIL reset_out_rst_n got=%b exp=0", out_rst_n); end
    checks++; if (timeout_count !== 8'd0) begin failures++; $display("FAIL reset_timeout got=%0d exp=0", timeout_count); end
    checks++; if (loss_count !== 8'd0) begin failures++; $display("FAIL reset_loss got=%0d exp=0", loss_count); end
  endtask

  task automatic test_lock_sequence();
    int n;
    logic s;
    rst_n = 1'b1;
    cycles_to_state(2'd1, n, s);
    checks++; if (n != R) begin failures++; $display("FAIL resetb_low_len got=%0d exp=%0d", n, R); end
    checks++; if (pll_resetb !== 1'b1) begin failures++; $display("FAIL wait_pll_resetb got=%b exp=1", pll_resetb); end
    cycles_to_state(2'd2, n, s);
    checks++; if (n != 1) begin failures++; $display("FAIL wait_to_stab got=%0d exp=1", n); end
    checks++; if (out_rst_n !== 1'b0) begin failures++; $display("FAIL stab_out_rst_n got=%b exp=0", out_rst_n); end
    cycles_to_state(2'd3, n, s);
    checks++; if (n != S) begin failures++; $display("FAIL stab_len got=%0d exp=%0d", n, S); end
    checks++; if (out_rst_n !== 1'b1) begin failures++; $display("FAIL run_out_rst_n got=%b exp=1", out_rst_n); end
    checks++; if (timeout_count !== 8'd0) begin failures++; $display("FAIL run_timeout got=%0d exp=0", timeout_count); end
  endtask

  task automatic test_run_loss();
    int n;
    logic s;
    pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_rst_n !== 1'b1) begin failures++; $display("FAIL loss_early got=%b exp=1", out_rst_n); end
    @(negedge clk);
    checks++; if (out_rst_n !== 1'b0) begin failures++; $display("FAIL loss_out_rst_n got=%b exp=0", out_rst_n); end
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL loss_state got=%0d exp=1", state); end
    checks++; if (loss_count !== 8'd1) begin failures++; $display("FAIL loss_count got=%0d exp=1", loss_count); end
    checks++; if (pll_resetb !== 1'b1) begin failures++; $display("FAIL loss_pll_resetb got=%b exp=1", pll_resetb); end
    pll_locked = 1'b1;
    cycles_to_state(2'd2, n, s);
    checks++; if (n != 3) begin failures++; $display("FAIL relock_to_stab got=%0d exp=3", n); end
    cycles_to_state(2'd3, n, s);
    checks++; if (n != S) begin failures++; $display("FAIL relock_stab_len got=%0d exp=%0d", n, S); end
    checks++; if (loss_count !== 8'd1 || timeout_count !== 8'd0) begin failures++; $display("FAIL relock_counts got=%0d/%0d exp=1/0", loss_count, timeout_count); end
  endtask

  task automatic test_reset_in_run();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (out_rst_n !== 1'b0 || pll_resetb !== 1'b0) begin failures++; $display("FAIL rir_outputs got=%b%b exp=00", out_rst_n, pll_resetb); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL rir_state got=%0d exp=0", state); end
    checks++; if (loss_count !== 8'd0 || timeout_count !== 8'd0) begin failures++; $display("FAIL rir_counts got=%0d/%0d exp=0/0", loss_count, timeout_count); end
    test_lock_sequence();
  endtask

  task automatic test_stabilise_glitch();
    int n;
    logic s;
    apply_reset(1'b1);
    rst_n = 1'b1;
    cycles_to_state(2'd2, n, s);
    checks++; if (n != R + 1) begin failures++; $display("FAIL glitch_setup got=%0d exp=%0d", n, R + 1); end
    repeat (G) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL glitch_hold1 got=%0d exp=2", state); end
    @(negedge clk);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL glitch_hold2 got=%0d exp=2", state); end
    @(negedge clk);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL glitch_back got=%0d exp=1", state); end
    cycles_to_state(2'd2, n, s);
    checks++; if (n != 1) begin failures++; $display("FAIL glitch_restab got=%0d exp=1", n); end
    cycles_to_state(2'd3, n, s);
    checks++; if (n != S) begin failures++; $display("FAIL glitch_full_len got=%0d exp=%0d", n, S); end
  endtask

  task automatic test_lock_at_timeout();
    int n;
    logic s;
    apply_reset(1'b0);
    rst_n = 1'b1;
    cycles_to_state(2'd1, n, s);
    repeat (T - 3) @(negedge clk);
    pll_locked = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL lat_wait got=%0d exp=1", state); end
    @(negedge clk);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL lat_state got=%0d exp=2", state); end
    checks++; if (timeout_count !== 8'd0) begin failures++; $display("FAIL lat_timeout got=%0d exp=0", timeout_count); end
    // One cycle later the timeout fires first.
    apply_reset(1'b0);
    rst_n = 1'b1;
    cycles_to_state(2'd1, n, s);
    repeat (T - 2) @(negedge clk);
    pll_locked = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL late_state got=%0d exp=0", state); end
    checks++; if (timeout_count !== 8'd1) begin failures++; $display("FAIL late_timeout got=%0d exp=1", timeout_count); end
  endtask

  task automatic test_timeout_saturation();
    int n;
    logic s;
    logic acc;
    apply_reset(1'b0);
    rst_n = 1'b1;
    cycles_to_state(2'd1, n, s);
    acc = s;
    for (int i = 1; i <= 3; i++) begin
      cycles_to_state(2'd0, n, s);
      acc = acc | s;
      checks++; if (n != T) begin failures++; $display("FAIL to_high_len[%0d] got=%0d exp=%0d", i, n, T); end
      checks++; if (timeout_count !== 8'(i)) begin failures++; $display("FAIL to_count[%0d] got=%0d exp=%0d", i, timeout_count, i); end
      cycles_to_state(2'd1, n, s);
      acc = acc | s;
      checks++; if (n != R) begin failures++; $display("FAIL to_low_len[%0d] got=%0d exp=%0d", i, n, R); end
    end
    for (int j = 4; j <= 260; j++) begin
      cycles_to_state(2'd0, n, s);
      acc = acc | s;
      if (j == 254) begin
        checks++; if (timeout_count !== 8'd254) begin failures++; $display("FAIL to_count_254 got=%0d exp=254", timeout_count); end
      end
      cycles_to_state(2'd1, n, s);
      acc = acc | s;
    end
    checks++; if (timeout_count !== 8'd255) begin failures++; $display("FAIL to_saturate got=%0d exp=255", timeout_count); end
    checks++; if (acc !== 1'b0) begin failures++; $display("FAIL to_out_rst_n_seen got=%b exp=0", acc); end
    checks++; if (loss_count !== 8'd0) begin failures++; $display("FAIL to_loss got=%0d exp=0", loss_count); end
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_run_loss();
    test_reset_in_run();
    test_stabilise_glitch();
    test_lock_at_timeout();
    test_timeout_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
